tlp_fifo_arbiter: RTL and testbench
===================================

# tlp_fifo_arbiter

Packet-granular round-robin arbiter that drains two first-word-fall-through TLP FIFOs (entries of type PCIE_FIFO64_RX) into the single TLP input of the Ethernet encapsulator. Source 0 is the PCIe RX TLP FIFO filled by the RX capture stage. Source 1 is the locally generated TLP FIFO. The block grants only whole, fully-buffered packets, strips filler entries, and bounds packet length with a watchdog so a malformed stream cannot lock the encapsulator.

## Interface
- MAX_WORDS, 512: longest legal packet in 64-bit words; word MAX_WORDS without tlast triggers truncation.
- CNT_W, 8: width of each per-source complete-packet counter.
- pcie_clk  in  1  sole clock.
- pcie_rst_n  in  1  asynchronous, active-low reset.
- src0_dout / src1_dout  in  PCIE_FIFO64_RX  FIFO head entry, FWFT.
- src0_empty / src1_empty  in  1  FIFO empty.
- src0_rd_en / src1_rd_en  out  1  pop head entry.
- src0_pkt_done / src1_pkt_done  in  1  writer pulse, one per written tlast entry.
- m_valid  out  1  output entry valid.
- m_ready  in  1  encapsulator accepts.
- m_data  out  PCIE_FIFO64_RX  forwarded entry; tlp.tlast forced to 1 on truncation.
- m_src  out  1  source index of the current packet.
- pkt_cnt0 / pkt_cnt1  out  CNT_W  buffered complete packets per source.
- err_overlong  out  1  sticky; a packet was truncated.
- err_cnt_ovf  out  1  sticky; pkt_done arrived with the counter at max.
- err_clr  in  1  synchronous clear of both sticky errors.

## Operation
- Per-source counter:
  - +1 on srcN_pkt_done.
  - −1 when a forwarded or flushed entry with data_valid=1 and tlp.tlast=1 is popped from that source.
  - Increment and decrement in the same cycle: no change.
  - Increment at all-ones: saturate and set err_cnt_ovf.
  - Decrement at 0: hold at 0 (must not occur).
- Filler entry: an entry with data_valid=0. Filler entries are popped and dropped in every state, one per cycle, never forwarded, and have no counter effect even if their tlast bit is 1.
- Counter register last_grant: reset 1, so source 0 wins first.
- States:
  - IDLE: if exactly one counter is nonzero, grant that source. If both are nonzero, grant !last_grant. On grant: set gnt, last_grant=gnt, clear word count wc, go to FWD. Filler entries at either head are dropped meanwhile.
  - FWD: head of source gnt with data_valid=1 and !empty drives m_valid=1 and m_data=head. On m_valid&&m_ready: pop and wc++.
    - Popped entry has tlast: go to IDLE.
    - Else, wc reaches MAX_WORDS−1 while forwarding a non-tlast entry: force m_data.tlp.tlast=1 on that entry, set err_overlong, go to FLUSH.
    - Empty head mid-packet: m_valid=0, wait; this is legal because the source's writer is behind.
  - FLUSH: pop source gnt every non-empty cycle without forwarding (m_valid=0) until an entry with data_valid=1 and tlast is popped. Decrement the counter on that pop, then go to IDLE.
- Only the granted source's rd_en may assert, except for filler drops at the other source's head while in IDLE.
- err_clr has priority over a same-cycle error set.
- Reset mid-packet: all state is lost. The encapsulator sees m_valid fall to 0 asynchronously; the FIFOs must be reset together with this block.

## Timing
- Reset values: state IDLE; m_valid 0; srcN_rd_en 0; m_src 0; pkt_cnt 0; errors 0; last_grant 1; wc 0.
- m_valid, m_data and srcN_rd_en are combinational from state and FIFO head; there is no output register.
- Latency: first cycle with counter > 0 is the IDLE decision; m_valid asserts the next cycle. A packet already complete at its first pkt_done pulse appears 2 cycles after the pulse.
- Throughput: 1 entry per cycle while m_ready is high. One IDLE cycle between packets.
- m_data stays stable while m_valid=1 and m_ready=0; no pop occurs in that case.
- pkt_cnt outputs are registered and reflect updates the cycle after the event.

## Test plan
- Three-word packet on source 0 only, m_ready=1: 3 consecutive m_valid beats starting 2 cycles after pkt_done, tlast on beat 3, pkt_cnt0 1→0, m_src=0.
- Both sources holding 2 packets each: output order src0, src1, src0, src1; one idle cycle between packets.
- Filler entry (data_valid=0, tlast=1) between two source-0 packets: never forwarded; pkt_cnt0 decrements exactly twice.
- m_ready toggling 1,0,0,1 during a 4-word packet: each entry seen exactly once; m_data held through stall cycles.
- MAX_WORDS=4, 6-word packet: beat 4 carries forced tlast; err_overlong=1; words 5–6 flushed; next packet follows normally; err_clr returns err_overlong to 0.
- CNT_W=2 with 4 pkt_done pulses and no drain: pkt_cnt0 saturates at 3 and err_cnt_ovf=1. An asynchronous reset asserted mid-packet drops m_valid immediately and clears all outputs.

Source files
------------

// File: rtl/tlp_fifo_arbiter.sv
// TLP FIFO entry type and a packet-granular round-robin arbiter that drains two
// FWFT TLP FIFOs into the single TLP input of the Ethernet encapsulator.
package pcie_fifo_pkg;
    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        tlast;
    } pcie_tlp64_t;

    typedef struct packed {
        logic        data_valid;
        pcie_tlp64_t tlp;
    } PCIE_FIFO64_RX;
endpackage

module tlp_fifo_arbiter
    import pcie_fifo_pkg::*;
#(
    parameter int unsigned MAX_WORDS = 512,
    parameter int unsigned CNT_W     = 8
) (
    input  logic             pcie_clk,
    input  logic             pcie_rst_n,
    input  PCIE_FIFO64_RX    src0_dout,
    input  logic             src0_empty,
    output logic             src0_rd_en,
    input  logic             src0_pkt_done,
    input  PCIE_FIFO64_RX    src1_dout,
    input  logic             src1_empty,
    output logic             src1_rd_en,
    input  logic             src1_pkt_done,
    output logic             m_valid,
    input  logic             m_ready,
    output PCIE_FIFO64_RX    m_data,
    output logic             m_src,
    output logic [CNT_W-1:0] pkt_cnt0,
    output logic [CNT_W-1:0] pkt_cnt1,
    output logic             err_overlong,
    output logic             err_cnt_ovf,
    input  logic             err_clr
);

    localparam int unsigned WcW = $clog2(MAX_WORDS);
    localparam logic [WcW-1:0] WcLast = WcW'(MAX_WORDS - 1);

    typedef enum logic [1:0] {StIdle, StFwd, StFlush} state_t;

    state_t           state_q, state_d;
    logic             gnt_q, gnt_d;
    logic             last_grant_q, last_grant_d;
    logic [WcW-1:0]   wc_q, wc_d;
    logic [CNT_W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;
    logic             err_overlong_q, err_cnt_ovf_q;
    logic             set_overlong, ovf0, ovf1, pop;
    logic             filler0, filler1, dec0, dec1;
    PCIE_FIFO64_RX    head;
    logic             head_empty;

    // Saturating up/down counter; MSB of the result flags an increment at all-ones.
    function automatic logic [CNT_W:0] cnt_next(input logic [CNT_W-1:0] cnt,
                                                input logic inc, input logic dec);
        logic [CNT_W:0] r;
        r = {1'b0, cnt};
        if (inc && !dec) begin
            if (&cnt) r[CNT_W] = 1'b1;
            else      r[CNT_W-1:0] = cnt + CNT_W'(1);
        end else if (dec && !inc && |cnt) begin
            r[CNT_W-1:0] = cnt - CNT_W'(1);
        end
        return r;
    endfunction

    assign head       = gnt_q ? src1_dout : src0_dout;
    assign head_empty = gnt_q ? src1_empty : src0_empty;
    assign filler0    = !src0_empty && !src0_dout.data_valid;
    assign filler1    = !src1_empty && !src1_dout.data_valid;

    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        last_grant_d = last_grant_q;
        wc_d         = wc_q;
        pop          = 1'b0;
        set_overlong = 1'b0;
        m_valid      = 1'b0;
        m_data       = head;
        src0_rd_en   = 1'b0;
        src1_rd_en   = 1'b0;
        unique case (state_q)
            StIdle: begin
                src0_rd_en = filler0;
                src1_rd_en = filler1;
                if (|cnt0_q || |cnt1_q) begin
                    if (|cnt0_q && |cnt1_q) gnt_d = !last_grant_q;
                    else                    gnt_d = |cnt1_q;
                    last_grant_d = gnt_d;
                    wc_d         = '0;
                    state_d      = StFwd;
                end
            end
            StFwd: begin
                if (!head_empty) begin
                    if (!head.data_valid) begin
                        pop = 1'b1;
                    end else begin
                        m_valid = 1'b1;
                        if (wc_q == WcLast) m_data.tlp.tlast = 1'b1;
                        if (m_ready) begin
                            pop = 1'b1;
                            if (head.tlp.tlast) begin
                                state_d = StIdle;
                            end else if (wc_q == WcLast) begin
                                set_overlong = 1'b1;
                                state_d      = StFlush;
                            end else begin
                                wc_d = wc_q + WcW'(1);
                            end
                        end
                    end
                end
            end
            StFlush: begin
                if (!head_empty) begin
                    pop = 1'b1;
                    if (head.data_valid && head.tlp.tlast) state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        if (pop) begin
            if (gnt_q) src1_rd_en = 1'b1;
            else       src0_rd_en = 1'b1;
        end
    end

    // A truncated entry pops with its original tlast=0, so only the real packet end decrements.
    assign dec0 = src0_rd_en && src0_dout.data_valid && src0_dout.tlp.tlast;
    assign dec1 = src1_rd_en && src1_dout.data_valid && src1_dout.tlp.tlast;
    assign {ovf0, cnt0_d} = cnt_next(cnt0_q, src0_pkt_done, dec0);
    assign {ovf1, cnt1_d} = cnt_next(cnt1_q, src1_pkt_done, dec1);

    always_ff @(posedge pcie_clk or negedge pcie_rst_n) begin
        if (!pcie_rst_n) begin
            state_q        <= StIdle;
            gnt_q          <= 1'b0;
            last_grant_q   <= 1'b1;
            wc_q           <= '0;
            cnt0_q         <= '0;
            cnt1_q         <= '0;
            err_overlong_q <= 1'b0;
            err_cnt_ovf_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            last_grant_q <= last_grant_d;
            wc_q         <= wc_d;
            cnt0_q       <= cnt0_d;
            cnt1_q       <= cnt1_d;
            if (err_clr) begin
                err_overlong_q <= 1'b0;
                err_cnt_ovf_q  <= 1'b0;
            end else begin
                if (set_overlong) err_overlong_q <= 1'b1;
                if (ovf0 || ovf1) err_cnt_ovf_q  <= 1'b1;
            end
        end
    end

    assign m_src        = gnt_q;
    assign pkt_cnt0     = cnt0_q;
    assign pkt_cnt1     = cnt1_q;
    assign err_overlong = err_overlong_q;
    assign err_cnt_ovf  = err_cnt_ovf_q;

endmodule

// File: tb/tb_tlp_fifo_arbiter.sv
// Bench for tlp_fifo_arbiter: FWFT FIFO models with writer pulses, a beat log,
// and an expected-beat scoreboard filled as packets are staged.
module tb_tlp_fifo_arbiter;
    import pcie_fifo_pkg::*;

    localparam int MaxWords = 4;
    localparam int CntW     = 2;

    logic            pcie_clk = 1'b0;
    logic            pcie_rst_n = 1'b0;
    PCIE_FIFO64_RX   src0_dout = '0, src1_dout = '0, m_data;
    logic            src0_empty = 1'b1, src1_empty = 1'b1;
    logic            src0_pkt_done = 1'b0, src1_pkt_done = 1'b0;
    logic            src0_rd_en, src1_rd_en, m_valid, m_src, err_overlong, err_cnt_ovf;
    logic            m_ready = 1'b0, err_clr = 1'b0;
    logic [CntW-1:0] pkt_cnt0, pkt_cnt1;

    tlp_fifo_arbiter #(.MAX_WORDS(MaxWords), .CNT_W(CntW)) dut (
        .pcie_clk     (pcie_clk),
        .pcie_rst_n   (pcie_rst_n),
        .src0_dout    (src0_dout),
        .src0_empty   (src0_empty),
        .src0_rd_en   (src0_rd_en),
        .src0_pkt_done(src0_pkt_done),
        .src1_dout    (src1_dout),
        .src1_empty   (src1_empty),
        .src1_rd_en   (src1_rd_en),
        .src1_pkt_done(src1_pkt_done),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .m_src        (m_src),
        .pkt_cnt0     (pkt_cnt0),
        .pkt_cnt1     (pkt_cnt1),
        .err_overlong (err_overlong),
        .err_cnt_ovf  (err_cnt_ovf),
        .err_clr      (err_clr)
    );

    always #5 pcie_clk = ~pcie_clk;

    // FIFO models: staged entries land at the next edge, with one writer pulse per packet.
    PCIE_FIFO64_RX fq0[$], fq1[$], stg0[$], stg1[$];
    int stg_rd0 = 0, stg_rd1 = 0;

    always @(posedge pcie_clk or negedge pcie_rst_n) begin : fifo_model
        logic done0, done1;
        done0 = 1'b0;
        done1 = 1'b0;
        if (!pcie_rst_n) begin
            fq0.delete();
            fq1.delete();
            stg_rd0 = stg0.size();
            stg_rd1 = stg1.size();
        end else begin
            if (src0_rd_en && fq0.size() > 0) void'(fq0.pop_front());
            if (src1_rd_en && fq1.size() > 0) void'(fq1.pop_front());
            while (stg_rd0 < stg0.size()) begin
                fq0.push_back(stg0[stg_rd0]);
                done0 = done0 | (stg0[stg_rd0].data_valid & stg0[stg_rd0].tlp.tlast);
                stg_rd0++;
            end
            while (stg_rd1 < stg1.size()) begin
                fq1.push_back(stg1[stg_rd1]);
                done1 = done1 | (stg1[stg_rd1].data_valid & stg1[stg_rd1].tlp.tlast);
                stg_rd1++;
            end
        end
        src0_pkt_done <= done0;
        src1_pkt_done <= done1;
        src0_empty    <= (fq0.size() == 0);
        src1_empty    <= (fq1.size() == 0);
        if (fq0.size() > 0) src0_dout <= fq0[0]; else src0_dout <= '0;
        if (fq1.size() > 0) src1_dout <= fq1[0]; else src1_dout <= '0;
    end

    typedef struct {
        PCIE_FIFO64_RX   d;
        logic            src;
        int              cyc;
        logic [CntW-1:0] cnt0;
    } beat_t;

    typedef struct {
        PCIE_FIFO64_RX d;
        logic          src;
    } exp_t;

    beat_t beat_log[$];
    exp_t  exp_q[$];
    int    cyc = 0;
    int    done_cyc0 = 0;

    always @(negedge pcie_clk) begin : monitor
        beat_t b;
        cyc++;
        if (src0_pkt_done) done_cyc0 = cyc;
        if (pcie_rst_n && m_valid && m_ready) begin
            b.d    = m_data;
            b.src  = m_src;
            b.cyc  = cyc;
            b.cnt0 = pkt_cnt0;
            beat_log.push_back(b);
        end
    end

    int errors = 0;
    int checks = 0;
    int log_rd = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge pcie_clk);
        #1;
    endtask

    function automatic PCIE_FIFO64_RX mk(input logic dv, input logic last, input logic [63:0] d);
        PCIE_FIFO64_RX w;
        w.data_valid = dv;
        w.tlp.data   = d;
        w.tlp.keep   = 8'hff;
        w.tlp.tlast  = last;
        return w;
    endfunction

    task automatic stage(input logic src, input PCIE_FIFO64_RX w);
        if (src) stg1.push_back(w);
        else     stg0.push_back(w);
    endtask

    task automatic push_pkt(input logic src, input int len, input logic [63:0] base);
        for (int i = 0; i < len; i++) stage(src, mk(1'b1, i == len - 1, base + 64'(i)));
        tick();
    endtask

    task automatic push_filler(input logic src);
        stage(src, mk(1'b0, 1'b1, 64'hdead));
        tick();
    endtask

    // Beats the encapsulator should see: truncated at MaxWords with tlast forced there.
    task automatic exp_pkt(input logic src, input int len, input logic [63:0] base);
        exp_t e;
        int   n;
        n = (len < MaxWords) ? len : MaxWords;
        for (int i = 0; i < n; i++) begin
            e.d   = mk(1'b1, (i == len - 1) || (i == MaxWords - 1), base + 64'(i));
            e.src = src;
            exp_q.push_back(e);
        end
    endtask

    task automatic drain(input string name);
        exp_t e;
        int   waited;
        waited = 0;
        while (exp_q.size() > 0) begin
            if (beat_log.size() > log_rd) begin
                e = exp_q.pop_front();
                check({name, " data"}, beat_log[log_rd].d, e.d);
                check({name, " src"}, beat_log[log_rd].src, e.src);
                log_rd++;
            end else if (waited > 200) begin
                check({name, " timeout, beats still owed"}, exp_q.size(), 0);
                exp_q.delete();
            end else begin
                @(negedge pcie_clk);
                waited++;
            end
        end
    endtask

    task automatic no_extra(input string name);
        repeat (4) tick();
        check({name, " extra beats"}, beat_log.size() - log_rd, 0);
        log_rd = beat_log.size();
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (!m_valid && n < 50) begin
            tick();
            n++;
        end
        check({name, " m_valid"}, m_valid, 1);
    endtask

    typedef struct {
        logic src;
        int   len;
        logic exp_ovl;
    } vec_t;

    vec_t vecs[5];
    int   s;

    initial begin
        vecs[0] = '{src: 1'b0, len: 3, exp_ovl: 1'b0};
        vecs[1] = '{src: 1'b1, len: 4, exp_ovl: 1'b0};
        vecs[2] = '{src: 1'b1, len: 6, exp_ovl: 1'b1};
        vecs[3] = '{src: 1'b0, len: 5, exp_ovl: 1'b1};
        vecs[4] = '{src: 1'b0, len: 1, exp_ovl: 1'b0};

        repeat (3) tick();
        check("reset m_valid", m_valid, 0);
        check("reset rd_en", {src1_rd_en, src0_rd_en}, 0);
        check("reset m_src", m_src, 0);
        check("reset pkt_cnt", {pkt_cnt1, pkt_cnt0}, 0);
        check("reset errors", {err_overlong, err_cnt_ovf}, 0);
        pcie_rst_n = 1'b1;
        tick();

        // Three-word packet on source 0: latency, back-to-back beats, counter 1 -> 0.
        m_ready = 1'b1;
        s = log_rd;
        push_pkt(1'b0, 3, 64'h100);
        exp_pkt(1'b0, 3, 64'h100);
        drain("pkt3");
        if (beat_log.size() >= s + 3) begin
            check("pkt3 latency", beat_log[s].cyc - done_cyc0, 2);
            check("pkt3 back-to-back", beat_log[s + 2].cyc - beat_log[s].cyc, 2);
            check("pkt3 cnt0 during", beat_log[s].cnt0, 1);
        end
        tick();
        check("pkt3 cnt0 after", pkt_cnt0, 0);
        no_extra("pkt3");

        // Two packets per source: round-robin order with one idle cycle between packets.
        m_ready = 1'b0;
        push_pkt(1'b0, 2, 64'h200);
        push_pkt(1'b1, 2, 64'h210);
        push_pkt(1'b0, 2, 64'h220);
        push_pkt(1'b1, 2, 64'h230);
        repeat (2) tick();
        check("rr cnt0 buffered", pkt_cnt0, 2);
        check("rr cnt1 buffered", pkt_cnt1, 2);
        exp_pkt(1'b0, 2, 64'h200);
        exp_pkt(1'b1, 2, 64'h210);
        exp_pkt(1'b0, 2, 64'h220);
        exp_pkt(1'b1, 2, 64'h230);
        s = log_rd;
        m_ready = 1'b1;
        drain("rr");
        if (beat_log.size() >= s + 8)
            for (int k = 2; k < 8; k += 2)
                check("rr idle gap", beat_log[s + k].cyc - beat_log[s + k - 1].cyc, 2);
        no_extra("rr");
        check("rr counters drained", {pkt_cnt1, pkt_cnt0}, 0);

        // Filler entries: dropped at an idle head and between packets, no counter effect.
        m_ready = 1'b0;
        push_filler(1'b1);
        tick();
        check("filler idle drop", src1_empty, 1);
        check("filler idle cnt1", pkt_cnt1, 0);
        push_pkt(1'b0, 2, 64'h300);
        push_filler(1'b0);
        push_pkt(1'b0, 2, 64'h310);
        repeat (2) tick();
        check("filler cnt0 buffered", pkt_cnt0, 2);
        exp_pkt(1'b0, 2, 64'h300);
        exp_pkt(1'b0, 2, 64'h310);
        m_ready = 1'b1;
        drain("filler");
        no_extra("filler");
        check("filler cnt0 drained", pkt_cnt0, 0);

        // Stall pattern 1,0,0,1 on a four-word packet.
        m_ready = 1'b0;
        push_pkt(1'b0, 4, 64'h400);
        exp_pkt(1'b0, 4, 64'h400);
        wait_valid("stall");
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        tick();
        check("stall valid 1", m_valid, 1);
        check("stall hold 1", m_data.tlp.data, 64'h401);
        tick();
        check("stall valid 2", m_valid, 1);
        check("stall hold 2", m_data.tlp.data, 64'h401);
        m_ready = 1'b1;
        drain("stall");
        no_extra("stall");
        check("stall no overlong", err_overlong, 0);

        // Table: single packets incl. truncation and recovery, then err_clr.
        for (int v = 0; v < 5; v++) begin
            push_pkt(vecs[v].src, vecs[v].len, 64'h1000 * (v + 1));
            exp_pkt(vecs[v].src, vecs[v].len, 64'h1000 * (v + 1));
            drain($sformatf("vec%0d", v));
            no_extra($sformatf("vec%0d", v));
            check($sformatf("vec%0d counter", v), vecs[v].src ? pkt_cnt1 : pkt_cnt0, 0);
            check($sformatf("vec%0d err_overlong", v), err_overlong, vecs[v].exp_ovl);
            err_clr = 1'b1;
            tick();
            err_clr = 1'b0;
            check($sformatf("vec%0d err_clr", v), err_overlong, 0);
        end

        // Counter saturation with no drain, then asynchronous reset mid-packet.
        m_ready = 1'b0;
        for (int p = 0; p < 4; p++) push_pkt(1'b0, 2, 64'h500 + 64'(16 * p));
        repeat (2) tick();
        check("sat cnt0", pkt_cnt0, 3);
        check("sat err_cnt_ovf", err_cnt_ovf, 1);
        check("sat holding beat", m_valid, 1);
        #2;
        pcie_rst_n = 1'b0;
        #1;
        check("arst m_valid", m_valid, 0);
        check("arst rd_en", {src1_rd_en, src0_rd_en}, 0);
        check("arst pkt_cnt", {pkt_cnt1, pkt_cnt0}, 0);
        check("arst errors", {err_overlong, err_cnt_ovf}, 0);
        check("arst m_src", m_src, 0);
        tick();
        pcie_rst_n = 1'b1;
        exp_q.delete();
        log_rd = beat_log.size();
        tick();
        m_ready = 1'b1;
        push_pkt(1'b1, 2, 64'h600);
        exp_pkt(1'b1, 2, 64'h600);
        drain("post-reset");
        no_extra("post-reset");
        check("post-reset cnt1", pkt_cnt1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
